// File: rtl/i2d_if.sv
// i2d_if: instruction fetch stage feeding i2d decode through a 2-deep prefetch buffer.
// A request killed by a redirect is parked in DISCARD until memory acks it.
module i2d_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] SWI_VEC  = 32'h0000_0008,
    parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        id_dis,
    input  logic        branch,
    input  logic [31:0] branch_pc,
    input  logic        swi,
    output logic [31:0] if_ins,
    output logic [31:0] if_pc,
    output logic        if_valid
);
    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;
    state_t           r_state, w_next;
    logic [31:0]      r_fetch_pc, r_addr, w_tgt;
    logic [1:0][31:0] r_bpc, r_bins;
    logic [1:0]       r_cnt, w_cnt_next;
    logic             w_redir, w_ack_wait, w_bypass, w_push, w_pop, w_widx;
    assign w_redir    = swi | branch;
    assign w_tgt      = (swi ? SWI_VEC : branch_pc) & ~32'h3;
    assign w_ack_wait = (r_state == WAIT) && imem_ack;
    assign w_bypass   = w_ack_wait && !id_dis && (r_cnt == 2'd0);
    assign w_push     = w_ack_wait && !w_bypass && !w_redir;
    assign w_pop      = !id_dis && (r_cnt != 2'd0) && !w_redir;
    assign w_cnt_next = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    // slot for a push is the post-pop occupancy; a push never sees r_cnt==2 without a pop
    assign w_widx     = r_cnt[0] ^ w_pop;
    assign imem_req   = (r_state != IDLE);
    assign imem_addr  = (r_state == DISCARD) ? r_addr : r_fetch_pc;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (!w_redir && r_cnt != 2'd2) ? WAIT : IDLE;
            WAIT:    w_next = w_redir ? (imem_ack ? IDLE : DISCARD) :
                              (imem_ack && w_cnt_next == 2'd2) ? IDLE : WAIT;
            DISCARD: w_next = imem_ack ? IDLE : DISCARD;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
        end else if (w_redir) begin
            r_fetch_pc <= w_tgt;
            if (r_state == WAIT) r_addr <= r_fetch_pc;
        end else if (w_ack_wait) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= 2'd0;
            r_bpc    <= '0;
            r_bins   <= '0;
            if_ins   <= NOP_INS;
            if_pc    <= 32'd0;
            if_valid <= 1'b0;
        end else begin
            r_cnt <= w_redir ? 2'd0 : w_cnt_next;
            if (w_pop) begin
                r_bpc[0]  <= r_bpc[1];
                r_bins[0] <= r_bins[1];
            end
            if (w_push) begin
                r_bpc[w_widx]  <= r_fetch_pc;
                r_bins[w_widx] <= imem_rdata;
            end
            if (w_redir) begin
                if_ins   <= NOP_INS;
                if_valid <= 1'b0;
            end else if (!id_dis) begin
                if_ins   <= w_pop ? r_bins[0] : w_bypass ? imem_rdata : NOP_INS;
                if_pc    <= w_pop ? r_bpc[0] : w_bypass ? r_fetch_pc : if_pc;
                if_valid <= w_pop | w_bypass;
            end
        end
    end
endmodule

// File: doc/i2d_if.md
Name: i2d_if

Overview:
Instruction fetch stage for the i2d core; the producer side of the IF->ID interface that i2d decode consumes (if_ins, if_pc, id_dis, branch, swi). Generates sequential PCs and issues word fetches on a req/ack instruction-memory port. Buffers up to two fetched words so ID stalls never drop instructions. Redirects on branch or software interrupt, flushing buffered and in-flight words.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
SWI_VEC, 32'h0000_0008, fetch target on swi
NOP_INS, 32'h0000_0000, word driven on if_ins when no valid instruction

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous active-low reset (rst==0 resets)
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  32  fetch word address, bits[1:0] always 0, stable while req && !ack
imem_ack  in  1  read data valid this cycle; may assert in the same cycle as req
imem_rdata  in  32  instruction word, sampled when imem_req && imem_ack
id_dis  in  1  ID stall: hold if_ins/if_pc/if_valid
branch  in  1  redirect to branch_pc (one-cycle pulse from ID)
branch_pc  in  32  branch target
swi  in  1  redirect to SWI_VEC (one-cycle pulse from ID)
if_ins  out  32  instruction to ID
if_pc  out  32  address of if_ins
if_valid  out  1  if_ins/if_pc hold a real instruction

Behaviour:
- Reset (async, rst==0): fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, buffer empty, state IDLE, if_ins=NOP_INS, if_pc=0, if_valid=0. Reset mid-fetch abandons the outstanding request; memory must tolerate req dropping.
- Prefetch buffer: 2-entry FIFO of {pc, ins}. occ = entries + (1 if request outstanding).
- FSM states: IDLE, WAIT, DISCARD.
  - IDLE: if occ<2, assert req with addr=fetch_pc -> WAIT.
  - WAIT: on ack, push {fetch_pc, rdata} (or bypass, below); fetch_pc+=4. If room remains after push, next req issues next cycle at fetch_pc+4 (stay WAIT, req stays high): zero-wait memory sustains one word per cycle. Else req=0 -> IDLE.
  - DISCARD: request killed by redirect; keep req/addr unchanged until ack, drop rdata, then -> IDLE (new target fetched from IDLE).
- Output register: at each edge with id_dis=0, load buffer head (pop) with if_valid=1; if buffer empty but ack arrives in WAIT, load imem_rdata/fetch_pc directly (bypass, no push); else load NOP_INS, if_pc unchanged, if_valid=0. With id_dis=1, outputs hold.
- Latency: ack at edge N -> instruction on if_ins after edge N when buffer empty and unstalled. First req asserts in the first cycle after rst deasserts.
- Redirect (branch or swi), priority swi > branch, overrides id_dis: at that edge flush buffer; if_ins=NOP_INS, if_valid=0; fetch_pc=target with bits[1:0] cleared; WAIT without ack -> DISCARD; WAIT with ack in same cycle -> word dropped, -> IDLE; IDLE stays IDLE. New target req asserts next cycle (or after discard ack).
- Redirect arriving in DISCARD: update fetch_pc only, stay DISCARD.
- fetch_pc wraps 32'hFFFF_FFFC -> 0 without error.
- Simultaneous push and pop: occupancy unchanged, FIFO order preserved.

Test Plan:
1. Reset release, memory acks same cycle as req -> imem_addr 0,4,8,... continuous req; if_ins/if_pc track with if_valid=1 from the first ack edge, one word per cycle.
2. id_dis high 5 cycles during streaming -> if_ins holds; buffer fills to 2, req drops; release -> remaining words delivered in order, none lost or duplicated.
3. Memory with 3-cycle ack latency, branch to 0x100 while request to 0x10 outstanding -> 0x10 data discarded on its ack, next req addr 0x100, if_valid=0 until 0x100 arrives.
4. swi and branch(0x200) same cycle -> next fetch addr SWI_VEC (0x8); branch_pc=0x203 alone -> fetch addr 0x200.
5. rst asserted while req outstanding and buffer holding 2 -> immediate outputs NOP_INS/0/0, req=0; after release fetch restarts at RESET_PC.
6. fetch_pc at 0xFFFF_FFFC -> next fetch addr 0x0000_0000.
